// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipe: RAW detection, ID-stage forwarding,
// whole-pipe freeze on multi-cycle data-memory accesses, and a saturating stall counter.
module hazard_ctrl #(
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_regwe,
    input  logic             ex_cregwa,
    input  logic [1:0]       ex_cregwd,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwe,
    input  logic             mem_cregwa,
    input  logic [1:0]       mem_cregwd,
    input  logic [4:0]       mem_rt,
    input  logic [4:0]       mem_rd,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             wb_regwe,
    input  logic             wb_cregwa,
    input  logic [4:0]       wb_rt,
    input  logic [4:0]       wb_rd,
    input  logic             branch_taken,
    output logic             pause_pc,
    output logic             pause_fi_id,
    output logic             bubble_id_ex,
    output logic             pause_ex_mem,
    output logic             pause_mem_wb,
    output logic             flush_fi_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    function automatic logic writes(input logic regwe, input logic cregwa,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [4:0] r);
        return regwe && (r != 5'd0) && ((cregwa ? rd : rt) == r);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic dep_mem, input logic mem_is_load,
                                           input logic dep_wb);
        if (dep_mem && !mem_is_load) return 2'd1;
        else if (dep_wb)             return 2'd2;
        else                         return 2'd0;
    endfunction

    logic dep_ex_rs, dep_ex_rt, dep_mem_rs, dep_mem_rt, dep_wb_rs, dep_wb_rt;
    logic mem_is_load, mw, ds;

    assign dep_ex_rs  = id_use_rs && writes(ex_regwe,  ex_cregwa,  ex_rt,  ex_rd,  id_rs);
    assign dep_ex_rt  = id_use_rt && writes(ex_regwe,  ex_cregwa,  ex_rt,  ex_rd,  id_rt);
    assign dep_mem_rs = id_use_rs && writes(mem_regwe, mem_cregwa, mem_rt, mem_rd, id_rs);
    assign dep_mem_rt = id_use_rt && writes(mem_regwe, mem_cregwa, mem_rt, mem_rd, id_rt);
    assign dep_wb_rs  = id_use_rs && writes(wb_regwe,  wb_cregwa,  wb_rt,  wb_rd,  id_rs);
    assign dep_wb_rt  = id_use_rt && writes(wb_regwe,  wb_cregwa,  wb_rt,  wb_rd,  id_rt);

    assign mem_is_load = (mem_cregwd == 2'd1);

    // An ALU producer in EX stalls once; a load stalls in EX and again from MEM.
    assign mw = (state_q == MEM_WAIT) || (mem_access && !dmem_ready);
    assign ds = dep_ex_rs || dep_ex_rt || (mem_is_load && (dep_mem_rs || dep_mem_rt));

    assign pause_pc     = mw || ds;
    assign pause_fi_id  = mw || ds;
    assign bubble_id_ex = !mw && ds;
    assign pause_ex_mem = mw;
    assign pause_mem_wb = mw;
    assign flush_fi_id  = branch_taken && !mw && !ds;
    assign fwd_a        = fwd_sel(dep_mem_rs, mem_is_load, dep_wb_rs);
    assign fwd_b        = fwd_sel(dep_mem_rt, mem_is_load, dep_wb_rt);
    assign mem_timeout  = timeout_q;
    assign stall_cnt    = stall_cnt_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WAIT_LAST) begin
                    // Give up on the access; it proceeds with whatever data is on the bus.
                    timeout_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        stall_cnt_d = (pause_fi_id && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-level model checked every cycle, plus literal pins.
module tb_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rt, ex_rd, mem_rt, mem_rd, wb_rt, wb_rd;
    logic id_use_rs, id_use_rt, ex_regwe, ex_cregwa, mem_regwe, mem_cregwa;
    logic [1:0] ex_cregwd, mem_cregwd;
    logic mem_access, dmem_ready, wb_regwe, wb_cregwa, branch_taken;
    logic pause_pc, pause_fi_id, bubble_id_ex, pause_ex_mem, pause_mem_wb, flush_fi_id;
    logic [1:0] fwd_a, fwd_b;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: are we waiting on memory, how long, timeout flag, stall cycles seen.
    bit m_waiting;
    int m_wait;
    bit m_to;
    int m_stall;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_regwe(ex_regwe), .ex_cregwa(ex_cregwa), .ex_cregwd(ex_cregwd),
        .ex_rt(ex_rt), .ex_rd(ex_rd),
        .mem_regwe(mem_regwe), .mem_cregwa(mem_cregwa), .mem_cregwd(mem_cregwd),
        .mem_rt(mem_rt), .mem_rd(mem_rd), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .wb_regwe(wb_regwe), .wb_cregwa(wb_cregwa), .wb_rt(wb_rt), .wb_rd(wb_rd),
        .branch_taken(branch_taken),
        .pause_pc(pause_pc), .pause_fi_id(pause_fi_id), .bubble_id_ex(bubble_id_ex),
        .pause_ex_mem(pause_ex_mem), .pause_mem_wb(pause_mem_wb), .flush_fi_id(flush_fi_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    function automatic bit wr(input bit we, input bit wa, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] r);
        logic [4:0] dst;
        dst = wa ? rd : rt;
        return we && r != 0 && dst == r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rt, ex_rd, mem_rt, mem_rd, wb_rt, wb_rd} = '0;
        {id_use_rs, id_use_rt, ex_regwe, ex_cregwa, mem_regwe, mem_cregwa} = '0;
        ex_cregwd = 2'd0; mem_cregwd = 2'd0;
        {mem_access, dmem_ready, wb_regwe, wb_cregwa, branch_taken} = '0;
    endtask

    task automatic model_reset();
        m_waiting = 0; m_wait = 0; m_to = 0; m_stall = 0;
    endtask

    // Compares every output against the rules; returns whether fetch is held this cycle.
    task automatic compare(output bit held);
        bit mw, ds, mld, dm_a, dm_b, dw_a, dw_b;
        int fa, fb;
        mw   = m_waiting || (mem_access && !dmem_ready);
        mld  = (mem_cregwd == 2'd1);
        dm_a = id_use_rs && wr(mem_regwe, mem_cregwa, mem_rt, mem_rd, id_rs);
        dm_b = id_use_rt && wr(mem_regwe, mem_cregwa, mem_rt, mem_rd, id_rt);
        dw_a = id_use_rs && wr(wb_regwe, wb_cregwa, wb_rt, wb_rd, id_rs);
        dw_b = id_use_rt && wr(wb_regwe, wb_cregwa, wb_rt, wb_rd, id_rt);
        ds   = (id_use_rs && wr(ex_regwe, ex_cregwa, ex_rt, ex_rd, id_rs))
            || (id_use_rt && wr(ex_regwe, ex_cregwa, ex_rt, ex_rd, id_rt))
            || (mld && (dm_a || dm_b));
        fa = (dm_a && !mld) ? 1 : (dw_a ? 2 : 0);
        fb = (dm_b && !mld) ? 1 : (dw_b ? 2 : 0);
        held = mw || ds;
        chk("m_pause_pc",     pause_pc,     held);
        chk("m_pause_fi_id",  pause_fi_id,  held);
        chk("m_bubble_id_ex", bubble_id_ex, !mw && ds);
        chk("m_pause_ex_mem", pause_ex_mem, mw);
        chk("m_pause_mem_wb", pause_mem_wb, mw);
        chk("m_flush_fi_id",  flush_fi_id,  branch_taken && !held);
        chk("m_fwd_a",        fwd_a,        fa);
        chk("m_fwd_b",        fwd_b,        fb);
        chk("m_mem_timeout",  mem_timeout,  m_to);
        chk("m_stall_cnt",    stall_cnt,    m_stall);
    endtask

    task automatic model_step(input bit held);
        if (held && m_stall < SAT) m_stall++;
        if (!m_waiting) begin
            if (mem_access && !dmem_ready) begin m_waiting = 1; m_wait = 1; end
        end else if (dmem_ready) begin
            m_waiting = 0; m_wait = 0;
        end else if (m_wait == WAIT_MAX - 1) begin
            m_to = 1; m_waiting = 0; m_wait = 0;
        end else begin
            m_wait++;
        end
    endtask

    // Entered and left at posedge+1; inputs stay put across the edge.
    task automatic tick();
        bit held;
        @(negedge clk);
        compare(held);
        @(posedge clk);
        if (!rst) model_reset(); else model_step(held);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_pause_pc", pause_pc, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mem_timeout", mem_timeout, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        #3;
        chk("reset_outputs", {pause_pc, pause_fi_id, bubble_id_ex, pause_ex_mem,
                              pause_mem_wb, flush_fi_id, fwd_a, fwd_b, mem_timeout}, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU producer in EX: one stall, then MEM forwarding.
        ex_regwe = 1; ex_cregwa = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        #1;
        chk("alu_pause_pc", pause_pc, 1);
        chk("alu_bubble", bubble_id_ex, 1);
        chk("alu_pause_ex_mem", pause_ex_mem, 0);
        tick();
        ex_regwe = 0; ex_rd = 0;
        mem_regwe = 1; mem_cregwa = 1; mem_rd = 5;
        #1;
        chk("alu_fwd_a", fwd_a, 1);
        chk("alu_released", pause_fi_id, 0);
        chk("alu_stall_cnt", stall_cnt, 1);
        tick();

        // Load-use with a taken branch held in ID across the stall.
        do_reset();
        ex_regwe = 1; ex_cregwa = 0; ex_rt = 8; ex_cregwd = 2'd1;
        id_rt = 8; id_use_rt = 1; branch_taken = 1;
        #1;
        chk("ld_ex_pause", pause_fi_id, 1);
        chk("ld_ex_flush", flush_fi_id, 0);
        tick();
        ex_regwe = 0; ex_rt = 0; ex_cregwd = 0;
        mem_regwe = 1; mem_cregwa = 0; mem_rt = 8; mem_cregwd = 2'd1;
        mem_access = 1; dmem_ready = 1;
        #1;
        chk("ld_mem_bubble", bubble_id_ex, 1);
        chk("ld_mem_pause_mem_wb", pause_mem_wb, 0);
        chk("ld_mem_fwd_b", fwd_b, 0);
        chk("ld_mem_flush", flush_fi_id, 0);
        tick();
        mem_regwe = 0; mem_rt = 0; mem_cregwd = 0; mem_access = 0; dmem_ready = 0;
        wb_regwe = 1; wb_cregwa = 0; wb_rt = 8;
        #1;
        chk("ld_wb_fwd_b", fwd_b, 2);
        chk("ld_wb_pause", pause_fi_id, 0);
        chk("ld_wb_flush", flush_fi_id, 1);
        chk("ld_stall_cnt", stall_cnt, 2);
        tick();
        clear_inputs();
        #1;
        chk("ld_flush_done", flush_fi_id, 0);
        tick();

        // Register 0 never hazards; MEM beats WB; unused operands never forward.
        ex_regwe = 1; ex_cregwa = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        mem_regwe = 1; mem_cregwa = 1; mem_rd = 0;
        #1;
        chk("r0_pause", pause_pc, 0);
        chk("r0_fwd_a", fwd_a, 0);
        tick();
        clear_inputs();
        mem_regwe = 1; mem_cregwa = 1; mem_rd = 7; wb_regwe = 1; wb_cregwa = 1; wb_rd = 7;
        id_rs = 7; id_use_rs = 1; id_rt = 7; id_use_rt = 0;
        #1;
        chk("prio_fwd_a", fwd_a, 1);
        chk("nouse_fwd_b", fwd_b, 0);
        tick();
        clear_inputs();
        tick();

        // Multi-cycle access: three not-ready cycles plus the ready cycle, EX dep pending.
        do_reset();
        mem_access = 1; dmem_ready = 0;
        ex_regwe = 1; ex_cregwa = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_pause_mem_wb", pause_mem_wb, 1);
            chk("mw_no_bubble", bubble_id_ex, 0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("mw_ready_pause", pause_pc, 1);
        tick();
        clear_inputs();
        #1;
        chk("mw_done_pause", pause_ex_mem, 0);
        chk("mw_stall_cnt", stall_cnt, 4);
        tick();

        // Timeout: ready never comes.
        mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_flag", mem_timeout, 1);
        mem_access = 0;
        #1;
        chk("to_released", pause_pc, 0);
        tick();
        tick();
        chk("to_sticky", mem_timeout, 1);
        chk("to_stall_cnt", stall_cnt, 8);

        // Asynchronous reset while waiting on memory.
        mem_access = 1; dmem_ready = 0;
        tick();
        tick();
        dmem_ready = 1;
        #1;
        chk("arst_pre_pause", pause_pc, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_pause_pc", pause_pc, 0);
        chk("arst_pause_mem_wb", pause_mem_wb, 0);
        chk("arst_timeout", mem_timeout, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Counter saturation under a long-held dependency.
        ex_regwe = 1; ex_cregwa = 0; ex_rt = 12; id_rt = 12; id_use_rt = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", stall_cnt, SAT);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
